// File: rtl/cim_pkg.sv
// Shared constants for the CIM partial-sum output path.
package cim_pkg;

  // Width of the global accumulator sum.
  localparam int NOUT_W        = 51;
  // Default width of a result word leaving the output buffer.
  localparam int OUT_W_DEFAULT = 16;
  // Width of the requantization shift amount.
  localparam int SHAMT_W       = 6;
  // Working width for rounding: one guard bit above the accumulator.
  localparam int ACC_W         = NOUT_W + 1;

endpackage

// File: rtl/cim_psum_requant.sv
// Combinational requantizer: rounds nout right by shamt (arithmetic,
// round-half-up), then saturates to a signed OUT_W-bit word.
// Used only when CIM_PSUM_REQUANT_EN is defined.
module cim_psum_requant
  import cim_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic [NOUT_W-1:0]  nout,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [OUT_W-1:0]   word,
  output logic               sat
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    signed'((ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1));
  // Two's complement: ~MAX equals -MAX-1, the most negative OUT_W value.
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;

  // The extra bit keeps nout + 2^(shamt-1) from overflowing.
  assign ext     = signed'({nout[NOUT_W-1], nout});
  assign rnd     = (shamt == '0) ? ext
                                 : ext + (ACC_W'(1) << (shamt - SHAMT_W'(1)));
  assign shifted = rnd >>> shamt;

  // Clamp to the signed output range and report when clamping occurred.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    word = shifted[OUT_W-1:0];
    sat  = 1'b0;
    if (shifted > MAX_V) begin
      word = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      word = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/cim_psum_outbuf.sv
// Output buffer behind the global accumulator. Captures nout on each
// rising edge of st, stores it in a DEPTH-entry FIFO and streams it out
// on a valid/ready interface. Dropped captures set the sticky ovf flag.
// Optional macro CIM_PSUM_REQUANT_EN: round/shift/saturate nout to OUT_W
// bits and report clamping on sat; otherwise nout is truncated.
module cim_psum_outbuf
  import cim_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NOUT_W-1:0]        nout,
  input  logic                     st,
  input  logic [SHAMT_W-1:0]       shamt,
  input  logic                     res_ready,
  input  logic                     clr_flags,
  output logic [OUT_W-1:0]         res_data,
  output logic                     res_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     sat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             st_q;
  logic             capture;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             ovf_evt;
  logic [OUT_W-1:0] word;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] mem [DEPTH];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign capture   = st & ~st_q;
  assign full      = (count == CNT_W'(DEPTH));
  assign res_valid = (count != '0);
  assign pop       = res_valid & res_ready;
  assign push_ok   = capture & (~full | pop);
  assign ovf_evt   = capture & full & ~pop;
  assign res_data  = res_valid ? mem[rd_ptr] : '0;

`ifdef CIM_PSUM_REQUANT_EN
  logic rq_sat;

  cim_psum_requant #(
    .OUT_W (OUT_W)
  ) u_requant (
    .nout  (nout),
    .shamt (shamt),
    .word  (word),
    .sat   (rq_sat)
  );

  // Sticky saturation flag; a new event in the clearing cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat <= 1'b0;
    end else if (push_ok && rq_sat) begin
      sat <= 1'b1;
    end else if (clr_flags) begin
      sat <= 1'b0;
    end
  end
`else
  logic unused_rq;

  assign word      = nout[OUT_W-1:0];
  assign sat       = 1'b0;
  assign unused_rq = ^{shamt, nout};
`endif

  // Edge detector; resetting st_q to 1 blocks a capture from a high st.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rstn) begin
      st_q <= 1'b1;
    end else begin
      st_q <= st;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy separately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; stale entries are never
    // visible because res_valid gates res_data and count starts at 0.
    if (push_ok) mem[wr_ptr] <= word;
  end

  // Sticky overflow flag; a new drop in the clearing cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (ovf_evt) begin
      ovf <= 1'b1;
    end else if (clr_flags) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cim_psum_outbuf.sv
// Scoreboard bench for cim_psum_outbuf: captures push expected words into
// a queue; a negedge monitor pops and compares on every accepted transfer.
module tb_cim_psum_outbuf;

  logic        clk = 1'b0;
  logic        rstn;
  logic [50:0] nout;
  logic        st;
  logic [5:0]  shamt;
  logic        res_ready;
  logic        clr_flags;
  logic [15:0] res_data;
  logic        res_valid;
  logic [2:0]  count;
  logic        ovf;
  logic        sat;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

`ifdef CIM_PSUM_REQUANT_EN
  localparam logic [15:0] E_1000  = 16'd125;
  localparam logic [15:0] E_M1000 = 16'hFF83;
  localparam logic [15:0] E_BIG   = 16'h7FFF;
  localparam logic [15:0] E_12345 = 16'h7FFF;
  localparam logic        S_BIG   = 1'b1;
  localparam logic        S_12345 = 1'b1;
`else
  localparam logic [15:0] E_1000  = 16'd1000;
  localparam logic [15:0] E_M1000 = 16'hFC18;
  localparam logic [15:0] E_BIG   = 16'h0000;
  localparam logic [15:0] E_12345 = 16'h2345;
  localparam logic        S_BIG   = 1'b0;
  localparam logic        S_12345 = 1'b0;
`endif

  cim_psum_outbuf #(
    .DEPTH (4),
    .OUT_W (16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .nout      (nout),
    .st        (st),
    .shamt     (shamt),
    .res_ready (res_ready),
    .clr_flags (clr_flags),
    .res_data  (res_data),
    .res_valid (res_valid),
    .count     (count),
    .ovf       (ovf),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rstn && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", {48'd0, res_data}, {48'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // One capture: st low for a cycle, then high. Called and returns at posedge+1.
  task automatic capture(input logic [50:0] n, input logic [5:0] sh,
                         input logic [15:0] e, input bit accepted,
                         input bit pop_now = 1'b0, input bit clr_now = 1'b0);
    logic saved;
    st    = 1'b0;
    nout  = n;
    shamt = sh;
    @(posedge clk); #1;
    st    = 1'b1;
    saved = res_ready;
    if (pop_now) res_ready = 1'b1;
    clr_flags = clr_now;
    if (accepted) exp_q.push_back(e);
    @(posedge clk); #1;
    res_ready = saved;
    clr_flags = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (count == 3'd0) break;
      @(posedge clk); #1;
    end
    check("drain_count", {61'd0, count}, 64'd0);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    st        = 1'b1;
    nout      = '0;
    shamt     = '0;
    res_ready = 1'b0;
    clr_flags = 1'b0;
    #2;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_valid", {63'd0, res_valid}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_sat", {63'd0, sat}, 64'd0);
    check("rst_data", {48'd0, res_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // st held high after reset must not capture.
    repeat (5) @(posedge clk);
    #1;
    check("hold_st_count", {61'd0, count}, 64'd0);
    check("hold_st_valid", {63'd0, res_valid}, 64'd0);

    // First capture with one-cycle latency.
    capture(51'd1000, 6'd3, E_1000, 1'b1);
    check("lat_valid", {63'd0, res_valid}, 64'd1);
    check("lat_count", {61'd0, count}, 64'd1);
    drain();

    // Signed value, saturation and flag clear; consumer always ready.
    capture(-51'sd1000, 6'd3, E_M1000, 1'b1);
    capture(51'd1048576, 6'd2, E_BIG, 1'b1);
    check("sat_big", {63'd0, sat}, {63'd0, S_BIG});
    pulse_clr();
    check("sat_clr", {63'd0, sat}, 64'd0);
    capture(51'h12345, 6'd0, E_12345, 1'b1);
    check("sat_12345", {63'd0, sat}, {63'd0, S_12345});
    pulse_clr();
    drain();

    // Overflow: fifth capture dropped; clear in the same cycle loses.
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) capture(51'(i), 6'd0, 16'(i), 1'b1);
    capture(51'd5, 6'd0, 16'd5, 1'b0, 1'b0, 1'b1);
    check("ovf_count", {61'd0, count}, 64'd4);
    check("ovf_set", {63'd0, ovf}, 64'd1);
    check("stall_head", {48'd0, res_data}, 64'd1);
    drain();
    check("ovf_sticky", {63'd0, ovf}, 64'd1);
    pulse_clr();
    check("ovf_clr", {63'd0, ovf}, 64'd0);

    // Full FIFO with a capture coinciding with a pop.
    res_ready = 1'b0;
    for (int i = 10; i <= 13; i++) capture(51'(i), 6'd0, 16'(i), 1'b1);
    check("full_count", {61'd0, count}, 64'd4);
    capture(51'd14, 6'd0, 16'd14, 1'b1, 1'b1);
    check("pushpop_count", {61'd0, count}, 64'd4);
    check("pushpop_ovf", {63'd0, ovf}, 64'd0);
    drain();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while holding entries.
    res_ready = 1'b0;
    for (int i = 20; i <= 22; i++) capture(51'(i), 6'd0, 16'(i), 1'b1);
    capture(51'd23, 6'd0, 16'd23, 1'b1);
    capture(51'd24, 6'd0, 16'd24, 1'b0);
    check("pre_rst_ovf", {63'd0, ovf}, 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_count", {61'd0, count}, 64'd0);
    check("arst_valid", {63'd0, res_valid}, 64'd0);
    check("arst_ovf", {63'd0, ovf}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_count", {61'd0, count}, 64'd0);
    check("post_rst_valid", {63'd0, res_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
